// File: rtl/ysyx_24110015_mem_arbiter.sv
// ysyx_24110015_mem_arbiter: IFU/LSU to single AXI4-Lite slave arbiter, one transaction per grant.
// Define ARB_RR_EN for round-robin between IFU and LSU; default is fixed priority LSU > IFU.
module ysyx_24110015_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [ADDR_W-1:0]   mem_araddr,
    output logic                mem_arvalid,
    input  logic                mem_arready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic [1:0]          mem_rresp,
    input  logic                mem_rvalid,
    output logic                mem_rready,
    output logic [ADDR_W-1:0]   mem_awaddr,
    output logic                mem_awvalid,
    input  logic                mem_awready,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wvalid,
    input  logic                mem_wready,
    input  logic [1:0]          mem_bresp,
    input  logic                mem_bvalid,
    output logic                mem_bready
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] IFU_RD = 2'd1;
    localparam logic [1:0] LSU_RD = 2'd2;
    localparam logic [1:0] LSU_WR = 2'd3;

    logic [1:0] state, next, idle_next;
    logic       ar_done, aw_done, w_done;
    logic       is_ifu, is_lr, is_lw, rd, done, pick_lsu;

    assign is_ifu = state == IFU_RD;
    assign is_lr  = state == LSU_RD;
    assign is_lw  = state == LSU_WR;
    assign rd     = is_ifu | is_lr;

`ifdef ARB_RR_EN
    logic last_grant;  // 1: IFU was granted last, so LSU wins the next tie
    assign pick_lsu = (lsu_awvalid | lsu_arvalid) & (~ifu_arvalid | last_grant);
    always_ff @(posedge clk) begin
        if (rst) last_grant <= 1'b0;
        else if (state == IDLE && next != IDLE) last_grant <= next == IFU_RD;
    end
`else
    assign pick_lsu = lsu_awvalid | lsu_arvalid;
`endif

    assign idle_next = pick_lsu ? (lsu_awvalid ? LSU_WR : LSU_RD) : ifu_arvalid ? IFU_RD : IDLE;
    assign done      = rd ? mem_rvalid & mem_rready : is_lw & mem_bvalid & mem_bready;
    assign next      = state == IDLE ? idle_next : done ? IDLE : state;

    // Handshake flags keep an accepted AR/AW/W from being offered to the slave twice
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= next;
            ar_done <= state != IDLE & (ar_done | (mem_arvalid & mem_arready));
            aw_done <= state != IDLE & (aw_done | (mem_awvalid & mem_awready));
            w_done  <= state != IDLE & (w_done | (mem_wvalid & mem_wready));
        end
    end

    assign mem_araddr  = is_ifu ? ifu_araddr : is_lr ? lsu_araddr : '0;
    assign mem_arvalid = rd & ~ar_done & (is_ifu ? ifu_arvalid : lsu_arvalid);
    assign ifu_arready = is_ifu & ~ar_done & mem_arready;
    assign lsu_arready = is_lr & ~ar_done & mem_arready;
    assign mem_rready  = (is_ifu & ifu_rready) | (is_lr & lsu_rready);
    assign ifu_rdata   = is_ifu ? mem_rdata : '0;
    assign ifu_rresp   = is_ifu ? mem_rresp : '0;
    assign ifu_rvalid  = is_ifu & mem_rvalid;
    assign lsu_rdata   = is_lr ? mem_rdata : '0;
    assign lsu_rresp   = is_lr ? mem_rresp : '0;
    assign lsu_rvalid  = is_lr & mem_rvalid;

    assign mem_awaddr  = is_lw ? lsu_awaddr : '0;
    assign mem_awvalid = is_lw & ~aw_done & lsu_awvalid;
    assign lsu_awready = is_lw & ~aw_done & mem_awready;
    assign mem_wdata   = is_lw ? lsu_wdata : '0;
    assign mem_wstrb   = is_lw ? lsu_wstrb : '0;
    assign mem_wvalid  = is_lw & ~w_done & lsu_wvalid;
    assign lsu_wready  = is_lw & ~w_done & mem_wready;
    assign mem_bready  = is_lw & lsu_bready;
    assign lsu_bresp   = is_lw ? mem_bresp : '0;
    assign lsu_bvalid  = is_lw & mem_bvalid;
endmodule
